// File: rtl/dot_product_pe.sv
// Signed dot-product processing element: K-cycle MAC of a shadowed A-row with a B-column, tagged result out via valid/ready.
// Optional build macro DOT_PRODUCT_PE_SAT_EN clamps res_data to the 2*DATA_W signed range and adds res_sat.
module dot_product_pe #(
    parameter int N      = 2,
    parameter int M      = 2,
    parameter int K      = 4,
    parameter int DATA_W = 8,
    localparam int N_W   = (N > 1) ? $clog2(N) : 1,
    localparam int M_W   = (M > 1) ? $clog2(M) : 1,
    localparam int K_W   = (K > 1) ? $clog2(K) : 1,
    localparam int ACC_W = 2*DATA_W + K_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_row,
    input  logic [K*DATA_W-1:0]     row_in,
    input  logic                    start_PE,
    input  logic [K*DATA_W-1:0]     col_in,
    input  logic [N_W-1:0]          n_in,
    input  logic [M_W-1:0]          m_in,
    output logic                    PE_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res_data,
    output logic [N_W-1:0]          res_n,
    output logic [M_W-1:0]          res_m
`ifdef DOT_PRODUCT_PE_SAT_EN
    ,
    output logic                    res_sat
`endif
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic [K_W-1:0] K_LAST = K_W'(K - 1);

    state_t                     state, state_nx;
    logic [K*DATA_W-1:0]        row_r;
    logic [K*DATA_W-1:0]        row_w;
    logic [K*DATA_W-1:0]        col_w;
    logic [N_W-1:0]             n_w;
    logic [M_W-1:0]             m_w;
    logic signed [ACC_W-1:0]    acc;
    logic [K_W-1:0]             k;
    logic signed [DATA_W-1:0]   a_e, b_e;
    logic signed [2*DATA_W-1:0] prod;

`ifdef DOT_PRODUCT_PE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-2*DATA_W+1){1'b0}}, {(2*DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-2*DATA_W+1){1'b1}}, {(2*DATA_W-1){1'b0}}};

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [2*DATA_W-1:0] sat_val(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[2*DATA_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[2*DATA_W-1:0];
        else                  return v[2*DATA_W-1:0];
    endfunction
`endif

    // MAC stage: select the k-th element pair and form the full-precision product
    assign a_e  = row_w[k*DATA_W +: DATA_W];
    assign b_e  = col_w[k*DATA_W +: DATA_W];
    assign prod = a_e * b_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row_r <= '0;
            row_w <= '0;
            col_w <= '0;
            n_w   <= '0;
            m_w   <= '0;
            acc   <= '0;
            k     <= '0;
        end else begin
            state <= state_nx;
            if (load_row)
                row_r <= row_in;
            case (state)
                IDLE: if (start_PE) begin
                    // Snapshot the shadow row before any same-cycle load lands
                    row_w <= row_r;
                    col_w <= col_in;
                    n_w   <= n_in;
                    m_w   <= m_in;
                    acc   <= '0;
                    k     <= '0;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (k != K_LAST)
                        k <= k + K_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_PE)       state_nx = MAC;
            MAC:     if (k == K_LAST)    state_nx = OUT;
            OUT:     if (res_ready)      state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    // Output stage: result is held in acc/tag registers until accepted
    assign PE_ready  = (state == IDLE);
    assign res_valid = (state == OUT);
    assign res_n     = n_w;
    assign res_m     = m_w;

`ifdef DOT_PRODUCT_PE_SAT_EN
    assign res_data = ACC_W'(sat_val(acc));
    assign res_sat  = (state == OUT) && sat_hit(acc);
`else
    assign res_data = acc;
`endif

endmodule

// File: tb/tb_dot_product_pe.sv
// Directed self-checking bench for dot_product_pe (K=4, DATA_W=8), both with and without DOT_PRODUCT_PE_SAT_EN.
module tb_dot_product_pe;

  localparam int N = 2, M = 2, K = 4, DATA_W = 8;
  localparam int ACC_W = 2*DATA_W + 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    load_row;
  logic [K*DATA_W-1:0]     row_in;
  logic                    start_PE;
  logic [K*DATA_W-1:0]     col_in;
  logic [0:0]              n_in;
  logic [0:0]              m_in;
  logic                    PE_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [ACC_W-1:0] res_data;
  logic [0:0]              res_n;
  logic [0:0]              res_m;
`ifdef DOT_PRODUCT_PE_SAT_EN
  logic                    res_sat;
`endif

  int total = 0;
  int bad   = 0;

  dot_product_pe #(.N(N), .M(M), .K(K), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_row(load_row), .row_in(row_in),
    .start_PE(start_PE), .col_in(col_in), .n_in(n_in), .m_in(m_in),
    .PE_ready(PE_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_n(res_n), .res_m(res_m)
`ifdef DOT_PRODUCT_PE_SAT_EN
    , .res_sat(res_sat)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [K*DATA_W-1:0] pack(input int e0, input int e1, input int e2, input int e3);
    logic [K*DATA_W-1:0] v;
    v[7:0]   = e0[7:0];
    v[15:8]  = e1[7:0];
    v[23:16] = e2[7:0];
    v[31:24] = e3[7:0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; load_row = 1'b0; row_in = '0; start_PE = 1'b0;
    col_in = '0; n_in = '0; m_in = '0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", PE_ready, 1'b1);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_data", res_data, 0);
    chk("rst_tag_n", res_n, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    load_row = 1'b1; row_in = pack(1, 2, 3, 4);
    tick();
    load_row = 1'b0; start_PE = 1'b1; col_in = pack(5, 6, 7, 8); n_in = 1'b1; m_in = 1'b0;
    res_ready = 1'b1;
    tick();
    start_PE = 1'b0;
    chk("basic_busy", PE_ready, 1'b0);
    chk("basic_early0", res_valid, 1'b0);
    tick(); tick(); tick();
    chk("basic_early3", res_valid, 1'b0);
    tick();
    chk("basic_valid", res_valid, 1'b1);
    chk("basic_data", res_data, 70);
    chk("basic_n", res_n, 1'b1);
    chk("basic_m", res_m, 1'b0);
    chk("basic_busy_out", PE_ready, 1'b0);
`ifdef DOT_PRODUCT_PE_SAT_EN
    chk("basic_nosat", res_sat, 1'b0);
`endif
    tick();
    chk("basic_ready_back", PE_ready, 1'b1);
    chk("basic_valid_drop", res_valid, 1'b0);

    load_row = 1'b1; row_in = pack(-128, -128, -128, -128);
    tick();
    load_row = 1'b0; start_PE = 1'b1; col_in = pack(-128, -128, -128, -128);
    n_in = 1'b0; m_in = 1'b1; res_ready = 1'b0;
    tick();
    start_PE = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ext_valid", res_valid, 1'b1);
`ifdef DOT_PRODUCT_PE_SAT_EN
    chk("ext_data_sat", res_data, 32767);
    chk("ext_sat", res_sat, 1'b1);
`else
    chk("ext_data", res_data, 65536);
`endif
    start_PE = 1'b1; col_in = pack(1, 1, 1, 1); n_in = 1'b1; m_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", res_valid, 1'b1);
`ifdef DOT_PRODUCT_PE_SAT_EN
      chk("bp_data", res_data, 32767);
`else
      chk("bp_data", res_data, 65536);
`endif
      chk("bp_n", res_n, 1'b0);
      chk("bp_m", res_m, 1'b1);
      chk("bp_busy", PE_ready, 1'b0);
    end
    start_PE = 1'b0; res_ready = 1'b1;
    tick();
    chk("bp_done_valid", res_valid, 1'b0);
    chk("bp_done_ready", PE_ready, 1'b1);

    load_row = 1'b1; row_in = pack(1, 1, 1, 1);
    tick();
    start_PE = 1'b1; col_in = pack(2, 2, 2, 2); row_in = pack(3, 3, 3, 3);
    n_in = 1'b1; m_in = 1'b1;
    tick();
    start_PE = 1'b0; load_row = 1'b0;
    tick(); tick(); tick(); tick();
    chk("shadow1_valid", res_valid, 1'b1);
    chk("shadow1_data", res_data, 8);
    chk("shadow1_m", res_m, 1'b1);
    tick();
    chk("shadow1_ready", PE_ready, 1'b1);
    start_PE = 1'b1; col_in = pack(1, 1, 1, 1); n_in = 1'b0; m_in = 1'b0;
    tick();
    start_PE = 1'b0;
    tick(); tick(); tick(); tick();
    chk("shadow2_valid", res_valid, 1'b1);
    chk("shadow2_data", res_data, 12);
    chk("shadow2_n", res_n, 1'b0);
    tick();

    start_PE = 1'b1; col_in = pack(1, 2, 3, 4); n_in = 1'b1; m_in = 1'b1;
    tick();
    start_PE = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", res_valid, 1'b0);
    chk("arst_ready", PE_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_result", res_valid, 1'b0);
    end

    load_row = 1'b1; row_in = pack(-1, 2, -3, 4);
    tick();
    load_row = 1'b0; start_PE = 1'b1; col_in = pack(5, -6, 7, 8); n_in = 1'b0; m_in = 1'b1;
    tick();
    start_PE = 1'b0;
    chk("fresh_busy", PE_ready, 1'b0);
    tick(); tick(); tick(); tick();
    chk("fresh_valid", res_valid, 1'b1);
    chk("fresh_data", res_data, -6);
    chk("fresh_m", res_m, 1'b1);
    tick();
    chk("fresh_ready", PE_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
